// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory port, branch redirect and decode valid/ready side.
// master is the fetch queue; slave is the memory/decode environment.
interface ifetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus4;
  logic [CW-1:0] count;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc, out_pc_plus4, count,
    input  mem_ack, mem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc, out_pc_plus4, count,
    output mem_ack, mem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: sequential word fetch over a req/ack memory port into a small FIFO,
// drained by decode through valid/ready; a branch redirect flushes and refetches.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset,
  ifetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_r;

  logic          pop;
  logic          push;
  logic [CW-1:0] cnt_after_pop;
  logic [CW-1:0] cnt_after_push;
  logic [31:0]   target;

  assign target         = bus.redirect_pc & 32'hFFFF_FFFC;
  assign bus.out_valid  = (count_r != '0);
  assign pop            = bus.out_valid && bus.out_ready && !bus.redirect;
  assign push           = (state == S_WAIT) && bus.mem_ack && !bus.redirect;
  assign cnt_after_pop  = count_r - CW'(pop);
  assign cnt_after_push = cnt_after_pop + CW'(push);

  // Head entry is read combinationally; outputs read zero while empty.
  assign bus.count        = count_r;
  assign bus.out_instr    = bus.out_valid ? instr_q[rd_ptr] : 32'h0;
  assign bus.out_pc       = bus.out_valid ? pc_q[rd_ptr]    : 32'h0;
  assign bus.out_pc_plus4 = bus.out_valid ? pc_q[rd_ptr] + 32'd4 : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= bus.mem_rdata;
      pc_q[wr_ptr]    <= bus.mem_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      fetch_pc     <= RESET_PC;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= 32'h0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_r      <= '0;
    end else begin
      // Redirect flushes; push is already suppressed so wr_ptr stays put.
      if (bus.redirect) begin
        rd_ptr  <= wr_ptr;
        count_r <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        count_r <= cnt_after_push;
      end

      case (state)
        S_IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= target;
          end else if (cnt_after_pop < CW'(DEPTH)) begin
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= fetch_pc;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.redirect) begin
            fetch_pc <= target;
            if (bus.mem_ack) begin
              bus.mem_req <= 1'b0;
              state       <= S_IDLE;
            end else begin
              state <= S_DROP;
            end
          end else if (bus.mem_ack) begin
            fetch_pc <= bus.mem_addr + 32'd4;
            // Keep streaming only if the next push is guaranteed to fit.
            if (cnt_after_push < CW'(DEPTH)) begin
              bus.mem_addr <= bus.mem_addr + 32'd4;
            end else begin
              bus.mem_req <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (bus.redirect) fetch_pc <= target;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Fetch stage feeding the decode pipeline register of the pipelined MIPS core.
- Generates sequential word fetch addresses and handshakes with a variable-latency instruction memory port (req/ack).
- Buffers fetched instructions, with their PCs, in a small FIFO.
- Presents them to decode through a valid/ready interface; a branch redirect flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mem_req  output  1  fetch request to instruction memory; registered.
- mem_addr  output  32  fetch byte address, word aligned; registered.
- mem_ack  input  1  memory returns mem_rdata for the current mem_addr this cycle.
- mem_rdata  input  32  instruction word; valid only while mem_ack=1.
- redirect  input  1  branch taken in execute; flush and refetch.
- redirect_pc  input  32  branch target; bits [1:0] ignored and treated as 0.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts the head this cycle (low = decode stall).
- out_instr  output  32  head instruction.
- out_pc  output  32  head instruction address.
- out_pc_plus4  output  32  out_pc + 4, used as the decode-stage PC+4.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset, asynchronous, dominant over all inputs: fetch_pc=RESET_PC, mem_req=0, mem_addr=0, FIFO empty (rd_ptr=wr_ptr=0), count=0, out_valid=0, state IDLE.
- out_valid = (count!=0). When out_valid=0, out_instr, out_pc and out_pc_plus4 read 0.
- FIFO read is combinational from the head entry.
- Pop occurs when out_valid && out_ready && !redirect.
- Pointers wrap modulo DEPTH. Arithmetic is mod 2^32; fetch_pc wraps from 32'hFFFFFFFC to 0.
- State IDLE:
  - If !redirect && count_next < DEPTH: set mem_req=1, mem_addr=fetch_pc, go to WAIT.
  - count_next is count after this cycle's pop.
- State WAIT (mem_req=1; mem_addr is held stable until ack):
  - mem_ack=1 && !redirect:
    - Push {mem_addr, mem_rdata}; fetch_pc = mem_addr+4.
    - If count_next (push and pop included) < DEPTH: keep mem_req=1, set mem_addr=mem_addr+4, stay in WAIT. This back-to-back path gives 1 instr/cycle with a zero-wait memory.
    - Otherwise: mem_req=0, go to IDLE.
  - mem_ack=0 && !redirect: hold.
  - redirect && mem_ack=1: discard data; mem_req=0; fetch_pc=redirect_pc; go to IDLE.
  - redirect && mem_ack=0: go to DROP; fetch_pc=redirect_pc.
- State DROP (request in flight is stale; mem_req stays 1 with the old mem_addr):
  - On mem_ack: discard data, mem_req=0, go to IDLE.
  - A further redirect in DROP only updates fetch_pc.
- Redirect in any state:
  - Empties the FIFO (rd_ptr=wr_ptr, count=0) at that edge.
  - A simultaneous out_ready pop is ignored; any simultaneous push is discarded.
  - The first entry after a redirect is redirect_pc, at the earliest 2 cycles later with a zero-wait memory.
- Latency: with a zero-wait memory (ack in the cycle mem_req is seen), the first out_valid occurs on the 2nd rising edge after reset deassertion.
- Full FIFO:
  - No new request is issued.
  - A request already in flight is never issued unless its push fits; the count_next rule guarantees this.
- Simultaneous push and pop when full: legal; count is unchanged.
- Invariant: never overflow, never underflow. count must always equal the number of valid entries.
- Memory-side rule: mem_ack while mem_req=0 is illegal and ignored.

Test Plan:
- Zero-wait memory with mem_rdata=addr^32'hA5A5A5A5, out_ready=1, reset released:
  - out_pc sequence 0,4,8,C,... one per cycle from the 2nd edge.
  - out_instr(4)=32'hA5A5A5A1; out_pc_plus4 = out_pc+4.
- out_ready=0 for 10 cycles with zero-wait memory:
  - count saturates at 4; mem_req drops to 0.
  - Entries at PCs 0,4,8,C are retained.
  - Raising out_ready drains 0,4,8,C and then resumes at 10 with no gap or duplicate.
- Memory ack delayed 3 cycles per fetch:
  - mem_addr held stable during the wait; out_valid toggles with one instr per 4 cycles.
  - Order preserved.
- redirect with redirect_pc=32'h00000103 while the queue holds 3 entries and mem_req is outstanding:
  - Queue empties the next cycle; in-flight ack data is discarded (DROP).
  - Next delivered out_pc=32'h00000100.
- redirect coincident with out_valid && out_ready and with mem_ack:
  - Neither pop nor push is recorded; count=0.
  - Next delivered out_pc=redirect_pc.
- Assert reset mid-WAIT with count=2:
  - All outputs return to reset values immediately, without waiting for clk.
  - After release, fetch restarts at RESET_PC.
